// File: rtl/idecode_pipe_if.sv
// Signal bundle between the IF/ID + WB side (master) and the decode stage (slave).
// Handshake: there is no valid/ready pair at the input. The master presents inst_in
// every cycle. When stall_out is high, the master holds inst_in and next_pc_in unchanged
// for that edge. valid_out marks a real instruction sitting in ID/EX.
interface idecode_pipe_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_BITS      = 32,
  parameter int REG_ADDR_BITS  = 5,
  parameter int EXEC_BUS_WIDTH = 7,
  parameter int MEM_BUS_WIDTH  = 3,
  parameter int WB_BUS_WIDTH   = 2,
  parameter int STALL_CNT_BITS = 16
);
  logic [DATA_WIDTH-1:0]     inst_in;
  logic [ADDR_BITS-1:0]      next_pc_in;
  logic                      flush_in;
  logic                      write_w;
  logic [REG_ADDR_BITS-1:0]  add_reg_w_in;
  logic [DATA_WIDTH-1:0]     reg_w_data_in;
  logic                      stall_out;
  logic                      valid_out;
  logic [EXEC_BUS_WIDTH-1:0] execute_bus_out;
  logic [MEM_BUS_WIDTH-1:0]  memory_bus_out;
  logic [WB_BUS_WIDTH-1:0]   wb_bus_out;
  logic [DATA_WIDTH-1:0]     reg_rs_data_out;
  logic [DATA_WIDTH-1:0]     reg_rt_data_out;
  logic [REG_ADDR_BITS-1:0]  add_reg_rs_out;
  logic [REG_ADDR_BITS-1:0]  add_reg_rt_out;
  logic [REG_ADDR_BITS-1:0]  add_reg_rd_out;
  logic [DATA_WIDTH-1:0]     inm_data_out;
  logic [DATA_WIDTH-1:0]     shamt_out;
  logic [ADDR_BITS-1:0]      next_pc_out;
  logic [STALL_CNT_BITS-1:0] stall_count_out;

  modport master (
    output inst_in, next_pc_in, flush_in, write_w, add_reg_w_in, reg_w_data_in,
    input  stall_out, valid_out, execute_bus_out, memory_bus_out, wb_bus_out,
           reg_rs_data_out, reg_rt_data_out, add_reg_rs_out, add_reg_rt_out,
           add_reg_rd_out, inm_data_out, shamt_out, next_pc_out, stall_count_out
  );

  modport slave (
    input  inst_in, next_pc_in, flush_in, write_w, add_reg_w_in, reg_w_data_in,
    output stall_out, valid_out, execute_bus_out, memory_bus_out, wb_bus_out,
           reg_rs_data_out, reg_rt_data_out, add_reg_rs_out, add_reg_rt_out,
           add_reg_rd_out, inm_data_out, shamt_out, next_pc_out, stall_count_out
  );
endinterface

// File: rtl/idecode_pipe.sv
// Instruction decode stage: register bank with WB bypass, control decode, load-use
// stall and the ID/EX pipeline register, plus a saturating stall counter.
module idecode_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_BITS      = 32,
  parameter int REG_ADDR_BITS  = 5,
  parameter int INM_DATA_WIDTH = 16,
  parameter int EXEC_BUS_WIDTH = 7,
  parameter int MEM_BUS_WIDTH  = 3,
  parameter int WB_BUS_WIDTH   = 2,
  parameter int MEM_READ_BIT   = 0,
  parameter int STALL_CNT_BITS = 16
) (
  input logic           clk,
  input logic           rst,
  idecode_pipe_if.slave id_if
);
  localparam int NUM_REGS = 2 ** REG_ADDR_BITS;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [DATA_WIDTH-1:0]     regs_q [NUM_REGS];

  logic                      valid_q;
  logic [EXEC_BUS_WIDTH-1:0] exec_q;
  logic [MEM_BUS_WIDTH-1:0]  mem_q;
  logic [WB_BUS_WIDTH-1:0]   wb_q;
  logic [DATA_WIDTH-1:0]     rs_data_q, rt_data_q, imm_q, shamt_q;
  logic [REG_ADDR_BITS-1:0]  rs_addr_q, rt_addr_q, rd_addr_q;
  logic [ADDR_BITS-1:0]      pc_q;
  logic [STALL_CNT_BITS-1:0] stall_cnt_q;

  logic [DATA_WIDTH-1:0]    inst;
  logic [5:0]               opcode, funct;
  logic                     nop_flag;
  logic [REG_ADDR_BITS-1:0] rs_addr, rt_addr, rd_addr;
  logic [6:0]               exec_dec;
  logic [2:0]               mem_dec;
  logic [1:0]               wb_dec;
  logic [DATA_WIDTH-1:0]    rs_data_d, rt_data_d;
  logic                     hazard, stall, bubble;

  assign inst     = id_if.inst_in;
  assign opcode   = inst[31:26];
  assign funct    = inst[5:0];
  assign nop_flag = (inst == '0);
  assign rs_addr  = inst[25:21];
  assign rt_addr  = inst[20:16];
  assign rd_addr  = inst[15:11];

  // Control decoder: exec = {reg_dst, alu_src, shamt_src, alu_op[3:0]},
  // mem = {branch, mem_write, mem_read}, wb = {mem_to_reg, reg_write}.
  always_comb begin
    exec_dec = '0;
    mem_dec  = '0;
    wb_dec   = '0;
    if (!nop_flag) begin
      case (opcode)
        OP_RTYPE: begin
          wb_dec = 2'b01;
          case (funct)
            6'h20:   exec_dec = 7'b1000010;
            6'h22:   exec_dec = 7'b1000110;
            6'h24:   exec_dec = 7'b1000000;
            6'h25:   exec_dec = 7'b1000001;
            6'h2a:   exec_dec = 7'b1000111;
            6'h00:   exec_dec = 7'b1011000;
            6'h02:   exec_dec = 7'b1011001;
            default: wb_dec   = 2'b00;
          endcase
        end
        OP_LW:   begin exec_dec = 7'b0100010; mem_dec = 3'b001; wb_dec = 2'b11; end
        OP_SW:   begin exec_dec = 7'b0100010; mem_dec = 3'b010; end
        OP_BEQ:  begin exec_dec = 7'b0000110; mem_dec = 3'b100; end
        OP_ADDI: begin exec_dec = 7'b0100010; wb_dec  = 2'b01; end
        default: ;
      endcase
    end
  end

  // Register 0 wins over bypass so a stray WB write to r0 can never leak through.
  always_comb begin
    rs_data_d = regs_q[rs_addr];
    rt_data_d = regs_q[rt_addr];
    if (id_if.write_w && id_if.add_reg_w_in != '0) begin
      if (id_if.add_reg_w_in == rs_addr) rs_data_d = id_if.reg_w_data_in;
      if (id_if.add_reg_w_in == rt_addr) rt_data_d = id_if.reg_w_data_in;
    end
    if (rs_addr == '0) rs_data_d = '0;
    if (rt_addr == '0) rt_data_d = '0;
  end

  assign hazard = valid_q && mem_q[MEM_READ_BIT] && (rt_addr_q != '0) &&
                  ((rt_addr_q == rs_addr) || (rt_addr_q == rt_addr)) && !nop_flag;
  assign stall  = hazard && !id_if.flush_in;
  assign bubble = id_if.flush_in || hazard || nop_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (id_if.write_w && id_if.add_reg_w_in != '0) begin
      regs_q[id_if.add_reg_w_in] <= id_if.reg_w_data_in;
    end
  end

  // Bubbles only kill valid and control; datapath fields load unconditionally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      exec_q    <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      imm_q     <= '0;
      shamt_q   <= '0;
      pc_q      <= '0;
    end else begin
      valid_q   <= !bubble;
      exec_q    <= bubble ? '0 : EXEC_BUS_WIDTH'(exec_dec);
      mem_q     <= bubble ? '0 : MEM_BUS_WIDTH'(mem_dec);
      wb_q      <= bubble ? '0 : WB_BUS_WIDTH'(wb_dec);
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      rs_addr_q <= rs_addr;
      rt_addr_q <= rt_addr;
      rd_addr_q <= rd_addr;
      imm_q     <= {{(DATA_WIDTH-INM_DATA_WIDTH){inst[INM_DATA_WIDTH-1]}},
                    inst[INM_DATA_WIDTH-1:0]};
      shamt_q   <= {{(DATA_WIDTH-5){1'b0}}, inst[10:6]};
      pc_q      <= id_if.next_pc_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign id_if.stall_out       = stall;
  assign id_if.valid_out       = valid_q;
  assign id_if.execute_bus_out = exec_q;
  assign id_if.memory_bus_out  = mem_q;
  assign id_if.wb_bus_out      = wb_q;
  assign id_if.reg_rs_data_out = rs_data_q;
  assign id_if.reg_rt_data_out = rt_data_q;
  assign id_if.add_reg_rs_out  = rs_addr_q;
  assign id_if.add_reg_rt_out  = rt_addr_q;
  assign id_if.add_reg_rd_out  = rd_addr_q;
  assign id_if.inm_data_out    = imm_q;
  assign id_if.shamt_out       = shamt_q;
  assign id_if.next_pc_out     = pc_q;
  assign id_if.stall_count_out = stall_cnt_q;
endmodule

// File: tb/tb_idecode_pipe.sv
// Directed bench for idecode_pipe: the driver queues the expected ID/EX contents for each
// edge, and a monitor pops and compares them after every rising edge.
module tb_idecode_pipe;
  localparam int CW    = 3;
  localparam int EXP_W = 189;

  localparam logic [6:0] EX_ADD = 7'b1000010, EX_SUB = 7'b1000110, EX_AND = 7'b1000000;
  localparam logic [6:0] EX_OR  = 7'b1000001, EX_SLT = 7'b1000111, EX_SLL = 7'b1011000;
  localparam logic [6:0] EX_IMM = 7'b0100010;
  localparam logic [5:0] OP_LW = 6'b100011, OP_ADDI = 6'b001000;

  typedef struct {
    logic [31:0] inst;
    logic        flush;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        stall;
    logic [6:0]  ex;
    logic [2:0]  mem;
    logic [1:0]  wb;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
  } vec_t;

  logic clk, rst, mon_en;
  logic [31:0] pc_ctr;
  logic [EXP_W-1:0] exp_q[$];
  int n_checks, n_pass;

  idecode_pipe_if #(.STALL_CNT_BITS(CW)) bus ();

  idecode_pipe #(.STALL_CNT_BITS(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .id_if (bus)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic vec_t mk(input logic [31:0] inst, input logic stall, input logic [6:0] ex,
                              input logic [2:0] mem, input logic [1:0] wb,
                              input logic [31:0] rs_d, rt_d);
    vec_t v;
    v.inst = inst; v.flush = 1'b0; v.we = 1'b0; v.wa = '0; v.wd = '0;
    v.stall = stall; v.ex = ex; v.mem = mem; v.wb = wb; v.rs_d = rs_d; v.rt_d = rt_d;
    return v;
  endfunction

  function automatic logic [EXP_W-1:0] pack(input logic full, valid, input logic [6:0] ex,
      input logic [2:0] mem, input logic [1:0] wb, input logic [31:0] rs_d, rt_d,
      input logic [4:0] rs_a, rt_a, rd_a, input logic [31:0] imm, sh, pc);
    return {full, valid, ex, mem, wb, rs_d, rt_d, rs_a, rt_a, rd_a, imm, sh, pc};
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge; presents one cycle of stimulus and queues what ID/EX must hold.
  task automatic drive(input vec_t v);
    logic [31:0] ins;
    ins = v.inst;
    bus.inst_in       = v.inst;
    bus.next_pc_in    = pc_ctr;
    bus.flush_in      = v.flush;
    bus.write_w       = v.we;
    bus.add_reg_w_in  = v.wa;
    bus.reg_w_data_in = v.wd;
    #1;
    check("stall_out", {31'd0, bus.stall_out}, {31'd0, v.stall});
    if (v.flush || v.stall || v.inst == 32'd0)
      exp_q.push_back(pack(1'b0, 1'b0, 7'd0, 3'd0, 2'd0, '0, '0, '0, '0, '0, '0, '0, '0));
    else
      exp_q.push_back(pack(1'b1, 1'b1, v.ex, v.mem, v.wb, v.rs_d, v.rt_d,
                           ins[25:21], ins[20:16], ins[15:11],
                           {{16{ins[15]}}, ins[15:0]}, {27'd0, ins[10:6]}, pc_ctr));
    pc_ctr = pc_ctr + 32'd4;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, bus.valid_out}, 32'd0);
    check({tag, "_ctrl"}, {20'd0, bus.execute_bus_out, bus.memory_bus_out, bus.wb_bus_out}, 32'd0);
    check({tag, "_rs_data"}, bus.reg_rs_data_out, 32'd0);
    check({tag, "_rt_data"}, bus.reg_rt_data_out, 32'd0);
    check({tag, "_addrs"}, {17'd0, bus.add_reg_rs_out, bus.add_reg_rt_out, bus.add_reg_rd_out}, 32'd0);
    check({tag, "_imm"}, bus.inm_data_out, 32'd0);
    check({tag, "_shamt"}, bus.shamt_out, 32'd0);
    check({tag, "_pc"}, bus.next_pc_out, 32'd0);
    check({tag, "_stall"}, {31'd0, bus.stall_out}, 32'd0);
    check({tag, "_cnt"}, {29'd0, bus.stall_count_out}, 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [EXP_W-1:0] exp_v, act_v;
    #2;
    if (mon_en && !rst) begin
      act_v = pack(1'b0, bus.valid_out, bus.execute_bus_out, bus.memory_bus_out,
                   bus.wb_bus_out, bus.reg_rs_data_out, bus.reg_rt_data_out,
                   bus.add_reg_rs_out, bus.add_reg_rt_out, bus.add_reg_rd_out,
                   bus.inm_data_out, bus.shamt_out, bus.next_pc_out);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL idex_unexpected: got %h with empty expected queue", act_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (exp_v[EXP_W-1] ? (act_v[EXP_W-2:0] === exp_v[EXP_W-2:0])
                           : (act_v[EXP_W-2:EXP_W-14] === exp_v[EXP_W-2:EXP_W-14]))
          n_pass++;
        else
          $display("FAIL idex_entry: got %h expected %h", act_v[EXP_W-2:0], exp_v[EXP_W-2:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_t v;
    n_checks = 0; n_pass = 0; mon_en = 1'b0; pc_ctr = 32'h0000_1000;
    rst = 1'b1;
    bus.inst_in = '0; bus.next_pc_in = '0; bus.flush_in = 1'b0;
    bus.write_w = 1'b0; bus.add_reg_w_in = '0; bus.reg_w_data_in = '0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // WB write of r3 bypassed into the same-cycle read
    v = mk(r_ins(5'd3, 5'd0, 5'd8, 5'd0, 6'h20), 1'b0, EX_ADD, 3'b000, 2'b01, 32'hDEADBEEF, 32'd0);
    v.we = 1'b1; v.wa = 5'd3; v.wd = 32'hDEADBEEF;
    drive(v);
    // sll with shamt 7, rt bypassed from WB
    v = mk(r_ins(5'd0, 5'd5, 5'd9, 5'd7, 6'h00), 1'b0, EX_SLL, 3'b000, 2'b01, 32'd0, 32'h12345678);
    v.we = 1'b1; v.wa = 5'd5; v.wd = 32'h12345678;
    drive(v);
    // negative immediate 0x8001 sign-extends
    drive(mk(i_ins(OP_ADDI, 5'd3, 5'd6, 16'h8001), 1'b0, EX_IMM, 3'b000, 2'b01, 32'hDEADBEEF, 32'd0));
    // WB write to r0 is ignored, r0 reads 0 even with bypass conditions
    v = mk(r_ins(5'd0, 5'd0, 5'd10, 5'd0, 6'h20), 1'b0, EX_ADD, 3'b000, 2'b01, 32'd0, 32'd0);
    v.we = 1'b1; v.wa = 5'd0; v.wd = 32'hFFFFFFFF;
    drive(v);
    drive(mk(32'd0, 1'b0, 7'd0, 3'd0, 2'd0, 32'd0, 32'd0));

    // load-use on rs: one stall, then reissue with the load value bypassed
    drive(mk(i_ins(OP_LW, 5'd3, 5'd4, 16'h0010), 1'b0, EX_IMM, 3'b001, 2'b11, 32'hDEADBEEF, 32'd0));
    drive(mk(r_ins(5'd4, 5'd5, 5'd11, 5'd0, 6'h20), 1'b1, EX_ADD, 3'b000, 2'b01, 32'd0, 32'd0));
    v = mk(r_ins(5'd4, 5'd5, 5'd11, 5'd0, 6'h20), 1'b0, EX_ADD, 3'b000, 2'b01, 32'hCAFEF00D, 32'h12345678);
    v.we = 1'b1; v.wa = 5'd4; v.wd = 32'hCAFEF00D;
    drive(v);
    check("cnt_after_loaduse", {29'd0, bus.stall_count_out}, 32'd1);

    // flush in the hazard cycle: no stall, bubble, counter unchanged
    drive(mk(i_ins(OP_LW, 5'd5, 5'd7, 16'h0000), 1'b0, EX_IMM, 3'b001, 2'b11, 32'h12345678, 32'd0));
    v = mk(r_ins(5'd7, 5'd3, 5'd12, 5'd0, 6'h22), 1'b0, EX_SUB, 3'b000, 2'b01, 32'd0, 32'd0);
    v.flush = 1'b1;
    drive(v);
    drive(mk(r_ins(5'd3, 5'd5, 5'd13, 5'd0, 6'h25), 1'b0, EX_OR, 3'b000, 2'b01, 32'hDEADBEEF, 32'h12345678));
    check("cnt_after_flush", {29'd0, bus.stall_count_out}, 32'd1);

    // load into r0 followed by a use of r0: no stall
    drive(mk(i_ins(OP_LW, 5'd5, 5'd0, 16'h0000), 1'b0, EX_IMM, 3'b001, 2'b11, 32'h12345678, 32'd0));
    drive(mk(r_ins(5'd0, 5'd0, 5'd14, 5'd0, 6'h24), 1'b0, EX_AND, 3'b000, 2'b01, 32'd0, 32'd0));
    check("cnt_after_r0", {29'd0, bus.stall_count_out}, 32'd1);

    // load-use on rt
    drive(mk(i_ins(OP_LW, 5'd0, 5'd4, 16'h0004), 1'b0, EX_IMM, 3'b001, 2'b11, 32'd0, 32'hCAFEF00D));
    drive(mk(r_ins(5'd3, 5'd4, 5'd15, 5'd0, 6'h2a), 1'b1, EX_SLT, 3'b000, 2'b01, 32'd0, 32'd0));
    drive(mk(r_ins(5'd3, 5'd4, 5'd15, 5'd0, 6'h2a), 1'b0, EX_SLT, 3'b000, 2'b01, 32'hDEADBEEF, 32'hCAFEF00D));
    check("cnt_after_rt_use", {29'd0, bus.stall_count_out}, 32'd2);

    // chained dependent loads: 8 more stalls, 10 total, counter saturates at 7
    drive(mk(i_ins(OP_LW, 5'd4, 5'd4, 16'h0000), 1'b0, EX_IMM, 3'b001, 2'b11, 32'hCAFEF00D, 32'hCAFEF00D));
    for (int k = 0; k < 8; k++) begin
      drive(mk(i_ins(OP_LW, 5'd4, 5'd4, 16'h0000), 1'b1, EX_IMM, 3'b001, 2'b11, 32'd0, 32'd0));
      drive(mk(i_ins(OP_LW, 5'd4, 5'd4, 16'h0000), 1'b0, EX_IMM, 3'b001, 2'b11, 32'hCAFEF00D, 32'hCAFEF00D));
    end
    check("cnt_saturated", {29'd0, bus.stall_count_out}, 32'd7);

    // asynchronous reset mid-run, away from any clock edge
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    // r5 was cleared by reset
    drive(mk(r_ins(5'd5, 5'd0, 5'd16, 5'd0, 6'h20), 1'b0, EX_ADD, 3'b000, 2'b01, 32'd0, 32'd0));
    drive(mk(32'd0, 1'b0, 7'd0, 3'd0, 2'd0, 32'd0, 32'd0));
    mon_en = 1'b0;

    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/idecode_pipe.md
# idecode_pipe

Parametrised instruction-decode stage with an integrated ID/EX pipeline register, an internal register bank with write-through bypass, load-use hazard detection and flush support. It sits between the IF/ID register and the execute stage. It decodes one instruction per cycle into registered control buses, operands, register addresses, a sign-extended immediate and a zero-extended shamt. It stalls upstream for one cycle on a load-use dependency and keeps a saturating stall counter for debug.

## Interface
- DATA_WIDTH, 32, instruction and register data width
- ADDR_BITS, 32, PC width
- REG_ADDR_BITS, 5, register address width; NUM_REGS = 2**REG_ADDR_BITS
- INM_DATA_WIDTH, 16, immediate field width before sign extension
- EXEC_BUS_WIDTH, 7 / MEM_BUS_WIDTH, 3 / WB_BUS_WIDTH, 2, control bus widths from the existing decoder module
- MEM_READ_BIT, 0, index in memory bus marking a load
- STALL_CNT_BITS, 16, stall counter width
- clk  in  1  clock; everything is on its rising edge
- rst  in  1  asynchronous, active-high reset
- inst_in  in  DATA_WIDTH  instruction from IF/ID
- next_pc_in  in  ADDR_BITS  PC+4 from IF/ID
- flush_in  in  1  squash the instruction currently in ID
- write_w  in  1  register-bank write enable from WB
- add_reg_w_in  in  REG_ADDR_BITS  WB destination register
- reg_w_data_in  in  DATA_WIDTH  WB write data
- stall_out  out  1  combinational; IF and IF/ID must hold when high
- valid_out  out  1  ID/EX holds a real instruction
- execute_bus_out / memory_bus_out / wb_bus_out  out  EXEC/MEM/WB_BUS_WIDTH  registered control
- reg_rs_data_out, reg_rt_data_out  out  DATA_WIDTH  registered operands
- add_reg_rs_out, add_reg_rt_out, add_reg_rd_out  out  REG_ADDR_BITS  registered fields [25:21], [20:16], [15:11]
- inm_data_out  out  DATA_WIDTH  registered sign-extended inst[15:0]
- shamt_out  out  DATA_WIDTH  registered zero-extended inst[10:6]
- next_pc_out  out  ADDR_BITS  registered next_pc_in
- stall_count_out  out  STALL_CNT_BITS  saturating count of stall cycles

## Operation
- Register bank: NUM_REGS x DATA_WIDTH, all cleared on rst. A write occurs at the clock edge when write_w=1 and add_reg_w_in≠0. Register 0 always reads 0.
- Bypass: a read of the register being written in the same cycle (write_w=1, address≠0) returns reg_w_data_in.
- Control: the existing decoder module is driven with opcode inst[31:26], funct inst[5:0] and nop_flag=(inst_in==0).
- Load-use hazard: hazard = valid_out & memory_bus_out[MEM_READ_BIT] & add_reg_rt_out≠0 & (add_reg_rt_out==inst[25:21] | add_reg_rt_out==inst[20:16]) & inst_in≠0.
- stall_out = hazard & ~flush_in.
- ID/EX update priority, each clock edge:
  1. rst: all ID/EX fields cleared.
  2. flush_in=1: bubble loaded.
  3. hazard=1: bubble loaded.
  4. inst_in==0: bubble loaded.
  5. Otherwise: the decoded instruction is loaded with valid_out=1.
- Bubble: valid_out=0 and all three control buses 0. Data, address and PC fields still load from the current inputs; they are don't-care downstream.
- stall_count_out increments on every cycle with stall_out=1 and saturates at all-ones. It is cleared only by rst.

## Timing
- Latency: 1 cycle from inst_in to the ID/EX outputs. stall_out is same-cycle combinational.
- A stall lasts exactly 1 cycle: after the bubble, valid_out=0, so the hazard term drops and the held instruction issues on the next edge with the loaded value bypassed from WB.
- Reset: all outputs 0 immediately on rst assertion (stall_out=0 because valid_out=0). The register bank and counter are cleared. Reset asserted mid-stall abandons the stall; no partial state survives.
- Simultaneous flush and hazard: flush wins, stall_out=0, bubble loaded.
- Simultaneous WB write and read of the same register: the bypass value is captured into ID/EX.
- A write to register 0 is ignored; a read of register 0 yields 0 even when bypass conditions hold.

## Test plan
- Reset: assert rst mid-run → all outputs 0 asynchronously; after release, reading r5 gives 0.
- Write/bypass: write_w=1, add_reg_w_in=3, reg_w_data_in=0xDEADBEEF while inst_in reads rs=3 → next cycle reg_rs_data_out=0xDEADBEEF.
- Immediate and shamt: inst_in with imm 0x8001 and shamt 7 → inm_data_out=0xFFFF8001, shamt_out=7.
- Load-use: lw into r4 then add using r4 as rs → stall_out=1 for 1 cycle, one bubble (valid_out=0), add issues next, stall_count_out=1.
- Flush during hazard: same sequence with flush_in=1 in the stall cycle → stall_out=0, bubble loaded, counter unchanged.
- Saturation and r0: a load targeting r0 followed by a use of r0 → no stall; forced 2^STALL_CNT_BITS+2 stall cycles (small parameter, e.g. 3 bits) → counter holds 7.
